// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the icache/dcache main-memory arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 28;
  localparam int MEM_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   pend_i,
  input  logic   pend_d,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);

  always_comb begin
    valid = pend_i | pend_d;
    grant = GNT_I;
    if (pend_i && pend_d) begin
      grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (pend_d) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide main memory between the icache (read-only) and the
// dcache (read/write), running one latched transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  state_t            state;
  grant_t            last_grant;
  logic              seen_busy;
  logic [ADDR_W-1:0] op_addr;
  logic              op_wr;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] i_hold;
  logic [DATA_W-1:0] d_hold;
  logic              read_q;
  logic              write_q;

  logic   pend_i;
  logic   pend_d;
  grant_t pick_grant;
  logic   pick_valid;
  logic   done;
  logic   done_i;
  logic   done_d;

  assign pend_i = i_read;
  assign pend_d = d_read | d_write;

  mem_arb_pick u_pick (
    .pend_i    (pend_i),
    .pend_d    (pend_d),
    .last_grant(last_grant),
    .grant     (pick_grant),
    .valid     (pick_valid)
  );

  // Memory must have been seen busy at least once; an early low busywait is
  // just a memory that has not reacted yet.
  assign done   = (state != IDLE) & seen_busy & ~mem_busywait;
  assign done_i = (state == GRANT_I) & done;
  assign done_d = (state == GRANT_D) & done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      seen_busy  <= 1'b0;
      op_addr    <= '0;
      op_wr      <= 1'b0;
      op_wdata   <= '0;
      i_hold     <= '0;
      d_hold     <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          seen_busy <= 1'b0;
          if (pick_valid) begin
            state      <= (pick_grant == GNT_I) ? GRANT_I : GRANT_D;
            last_grant <= pick_grant;
            op_addr    <= (pick_grant == GNT_I) ? i_address : d_address;
            op_wr      <= (pick_grant == GNT_D) & d_write;
            op_wdata   <= d_writedata;
            read_q     <= ~((pick_grant == GNT_D) & d_write);
            write_q    <= (pick_grant == GNT_D) & d_write;
          end
        end
        GRANT_I, GRANT_D: begin
          if (done) begin
            state     <= IDLE;
            seen_busy <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            // Returned line lands in the owner's hold even if it dropped its request.
            if (!op_wr && state == GRANT_I) i_hold <= mem_readdata;
            if (!op_wr && state == GRANT_D) d_hold <= mem_readdata;
          end else if (mem_busywait) begin
            seen_busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_read      = read_q;
  assign mem_write     = write_q;
  assign mem_address   = op_addr;
  assign mem_writedata = op_wdata;

  assign i_busywait = ~reset & pend_i & ~done_i;
  assign d_busywait = ~reset & pend_d & ~done_d;
  assign i_readdata = done_i ? mem_readdata : i_hold;
  assign d_readdata = done_d ? mem_readdata : d_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory, a spec-level model
// checked every cycle, and literal expectations for each scenario.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [DW-1:0] IDLE_PAT = {4{32'hDEAD_BEEF}};

  logic          clock;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_writedata;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  mem_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_busywait   (i_busywait),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_readdata   (d_readdata),
    .d_busywait   (d_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Behavioural main memory: optional quiet cycles, then busy for lat cycles.
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  int pre_lat = 0;
  int busy_lat = 4;
  int mcnt = 0;

  initial begin
    mem_busywait = 1'b0;
    mem_readdata = IDLE_PAT;
    forever begin
      @(posedge clock);
      #1;
      if (reset || !(mem_read || mem_write)) begin
        mcnt = 0;
        mem_busywait = 1'b0;
        mem_readdata = IDLE_PAT;
      end else begin
        mcnt++;
        if (mcnt <= pre_lat) mem_busywait = 1'b0;
        else if (mcnt <= pre_lat + busy_lat) mem_busywait = 1'b1;
        else begin
          mem_busywait = 1'b0;
          if (mem_write && mcnt == pre_lat + busy_lat + 1) mem_model[mem_address] = mem_writedata;
        end
        mem_readdata = mem_model.exists(mem_address) ? mem_model[mem_address] : '0;
      end
    end
  end

  // Spec-level model: owner 0 = none, 1 = icache, 2 = dcache.
  int            m_owner;
  int            m_last;
  logic          m_seen;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_ihold;
  logic [DW-1:0] m_dhold;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_owner <= 0; m_last <= 1; m_seen <= 1'b0; m_addr <= '0; m_wr <= 1'b0;
      m_wdata <= '0; m_ihold <= '0; m_dhold <= '0;
    end else if (m_owner == 0) begin
      int win;
      win = 0;
      if (i_read && (d_read || d_write)) win = (m_last == 1) ? 2 : 1;
      else if (i_read) win = 1;
      else if (d_read || d_write) win = 2;
      m_seen <= 1'b0;
      if (win != 0) begin
        m_owner <= win;
        m_last  <= win;
        m_addr  <= (win == 1) ? i_address : d_address;
        m_wr    <= (win == 2) && d_write;
        m_wdata <= d_writedata;
      end
    end else if (m_seen && !mem_busywait) begin
      m_owner <= 0;
      m_seen  <= 1'b0;
      if (!m_wr && m_owner == 1) m_ihold <= mem_readdata;
      if (!m_wr && m_owner == 2) m_dhold <= mem_readdata;
    end else if (mem_busywait) begin
      m_seen <= 1'b1;
    end
  end

  function automatic bit model_done(input int who);
    return (m_owner == who) && m_seen && !mem_busywait;
  endfunction

  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en) begin
      check("mem_read", mem_read, (m_owner != 0) && !m_wr);
      check("mem_write", mem_write, (m_owner != 0) && m_wr);
      if (m_owner != 0 || reset) begin
        check("mem_address", mem_address, m_addr);
        check("mem_writedata", mem_writedata, m_wdata);
      end
      check("i_busywait", i_busywait, !reset && i_read && !model_done(1));
      check("d_busywait", d_busywait, !reset && (d_read || d_write) && !model_done(2));
      check("i_readdata", i_readdata, model_done(1) ? mem_readdata : m_ihold);
      check("d_readdata", d_readdata, model_done(2) ? mem_readdata : m_dhold);
    end
  end

  // Transaction monitor: start address, op and idle cycles before each grant.
  logic [AW-1:0] g_addr_q[$];
  logic          g_wr_q[$];
  logic [DW-1:0] g_wdata_q[$];
  int            g_gap_q[$];
  int            idle_cnt = 0;
  logic          prev_act = 1'b0;

  always @(negedge clock) begin
    if (mem_read || mem_write) begin
      if (!prev_act) begin
        g_addr_q.push_back(mem_address);
        g_wr_q.push_back(mem_write);
        g_wdata_q.push_back(mem_writedata);
        g_gap_q.push_back(idle_cnt);
      end
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    prev_act = mem_read || mem_write;
  end

  logic [AW-1:0] i_addrs[4];
  logic [AW-1:0] d_addrs[4];
  logic          d_wrs[4];
  logic [DW-1:0] d_wdatas[4];
  int            i_done_q[$];
  int            d_done_q[$];

  task automatic drive_d(input int k);
    d_address   = d_addrs[k];
    d_write     = d_wrs[k];
    d_read      = !d_wrs[k];
    d_writedata = d_wdatas[k];
  endtask

  // Each port issues its list back-to-back, dropping after its last done.
  task automatic run(input int ni, input int nd, input int max_cyc);
    int ic = 0;
    int dc = 0;
    int cyc = 0;
    bit i_next = 0;
    bit d_next = 0;
    @(posedge clock); #2;
    i_done_q.delete(); d_done_q.delete();
    g_addr_q.delete(); g_wr_q.delete(); g_wdata_q.delete(); g_gap_q.delete();
    idle_cnt = 0;
    i_read = (ni > 0);
    i_address = i_addrs[0];
    if (nd > 0) drive_d(0);
    while (cyc < max_cyc) begin
      @(negedge clock);
      if (i_read && !i_busywait) begin i_done_q.push_back(cyc); ic++; i_next = 1; end
      if ((d_read || d_write) && !d_busywait) begin d_done_q.push_back(cyc); dc++; d_next = 1; end
      @(posedge clock); #2;
      cyc++;
      if (i_next) begin
        if (ic < ni) i_address = i_addrs[ic];
        else i_read = 1'b0;
        i_next = 0;
      end
      if (d_next) begin
        if (dc < nd) drive_d(dc);
        else begin d_read = 1'b0; d_write = 1'b0; end
        d_next = 0;
      end
      if (ic >= ni && dc >= nd) break;
    end
    check("run_completed", ic + dc, ni + nd);
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_read = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_writedata = '0;
    mem_model[28'h0000010] = {16{8'hA5}};
    mem_model[28'h0000020] = {4{32'h2020_0202}};
    mem_model[28'h0000030] = {4{32'h3030_0303}};
    mem_model[28'h0000031] = {4{32'h3131_1313}};
    mem_model[28'h0000040] = {4{32'h4040_0404}};
    mem_model[28'h0000050] = {4{32'h5050_0505}};
    mem_model[28'h0000060] = {4{32'h6060_0606}};
    mem_model[28'h0000070] = {4{32'h7070_0707}};
    @(posedge clock);
    cmp_en = 1'b1;
    @(negedge clock);
    check("reset_mem_read", mem_read, 1'b0);
    check("reset_i_readdata", i_readdata, '0);
    @(posedge clock); #2 reset = 1'b0;

    // 1: icache only
    i_addrs[0] = 28'h0000010;
    run(1, 0, 40);
    check("t1_done_cycle", i_done_q[0], 5);
    check("t1_addr", g_addr_q[0], 28'h0000010);
    check("t1_start_cycle", g_gap_q[0], 1);
    check("t1_is_read", g_wr_q[0], 1'b0);
    check("t1_hold", i_readdata, {16{8'hA5}});

    // 2: dcache write-back
    d_addrs[0] = 28'h00000FF; d_wrs[0] = 1'b1; d_wdatas[0] = {8{16'h1234}};
    run(0, 1, 40);
    check("t2_done_cycle", d_done_q[0], 5);
    check("t2_is_write", g_wr_q[0], 1'b1);
    check("t2_wdata", g_wdata_q[0], {8{16'h1234}});
    check("t2_mem_stored", mem_model[28'h00000FF], {8{16'h1234}});

    // 3: simultaneous requests right after reset; first tie goes to dcache
    do_reset();
    i_addrs[0] = 28'h0000010;
    d_addrs[0] = 28'h0000020; d_wrs[0] = 1'b0; d_wdatas[0] = '0;
    run(1, 1, 60);
    check("t3_first_addr", g_addr_q[0], 28'h0000020);
    check("t3_second_addr", g_addr_q[1], 28'h0000010);
    check("t3_gap", g_gap_q[1], 1);
    check("t3_d_done", d_done_q[0], 5);
    check("t3_i_done", i_done_q[0], 11);

    // 4: dcache back-to-back with icache waiting
    i_addrs[0] = 28'h0000040;
    d_addrs[0] = 28'h0000030; d_wrs[0] = 1'b0;
    d_addrs[1] = 28'h0000031; d_wrs[1] = 1'b0; d_wdatas[1] = '0;
    run(1, 2, 80);
    check("t4_grant0", g_addr_q[0], 28'h0000030);
    check("t4_grant1", g_addr_q[1], 28'h0000040);
    check("t4_grant2", g_addr_q[2], 28'h0000031);
    check("t4_i_done", i_done_q[0], 11);
    check("t4_d_done2", d_done_q[1], 17);
    check("t4_d_hold", d_readdata, {4{32'h3131_1313}});

    // 5: reset mid-grant while memory is busy
    @(posedge clock); #2;
    i_read = 1'b1; i_address = 28'h0000050;
    repeat (3) @(negedge clock);
    check("t5_pre_busy", mem_busywait, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_mem_read", mem_read, 1'b0);
    check("t5_rst_i_busy", i_busywait, 1'b0);
    check("t5_rst_d_busy", d_busywait, 1'b0);
    @(posedge clock); #2 reset = 1'b0;
    @(negedge clock);
    check("t5_idle_mem_read", mem_read, 1'b0);
    check("t5_idle_i_busy", i_busywait, 1'b1);
    @(negedge clock);
    check("t5_regrant_read", mem_read, 1'b1);
    check("t5_regrant_addr", mem_address, 28'h0000050);
    begin
      int w = 0;
      while (i_busywait && w < 20) begin @(negedge clock); w++; end
      check("t5_completes", i_busywait, 1'b0);
    end
    @(posedge clock); #2 i_read = 1'b0;
    @(negedge clock);

    // 6a: memory slow to assert busy
    pre_lat = 2; busy_lat = 2;
    i_addrs[0] = 28'h0000060;
    run(1, 0, 40);
    check("t6a_done_cycle", i_done_q[0], 5);
    check("t6a_hold", i_readdata, {4{32'h6060_0606}});

    // 6b: icache drops its request mid-grant
    pre_lat = 0; busy_lat = 4;
    @(posedge clock); #2;
    i_read = 1'b1; i_address = 28'h0000070;
    repeat (2) @(posedge clock);
    #2 i_read = 1'b0;
    @(negedge clock);
    check("t6b_still_reading", mem_read, 1'b1);
    check("t6b_no_stall", i_busywait, 1'b0);
    begin
      int w = 0;
      while (mem_read && w < 20) begin @(negedge clock); w++; end
      check("t6b_finished", mem_read, 1'b0);
    end
    @(negedge clock);
    check("t6b_hold", i_readdata, {4{32'h7070_0707}});

    repeat (2) @(negedge clock);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
